fc_tile_sequencer: RTL and testbench
====================================

Name: fc_tile_sequencer

Overview:
- Sequences one fully-connected layer (default 1x784 by 784x64, 16-bit signed fixed point) through a smaller vector-matrix PE tile of 1xTILE_K by TILE_KxOUT_LEN.
- Per tile: addresses activation/weight memory, runs the PE, collects its OUT_LEN partial sums and accumulates them at widened precision.
- After the last tile, saturates the sums to DW bits and presents them with a valid/ready handshake.
- Sits between the layer-level controller and the PE/weight-buffer pair.

Parameters:
- DW, 16, data width of activations, weights and PE psum elements (signed two's complement)
- IN_LEN, 784, input vector length; must be a multiple of TILE_K
- OUT_LEN, 64, output vector length (PE columns)
- TILE_K, 16, input elements per PE pass; NTILES = IN_LEN/TILE_K (49 by default)
- MEM_LAT, 2, cycles from tile_addr change to tile data valid at the PE inputs (>=1)
- TIMEOUT, 256, maximum cycles in RUN waiting for pe_finish
- ACC_W, DW+6, accumulator width; must be >= DW+clog2(NTILES)

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-high reset
- start, in, 1, one-cycle request to process one layer
- busy, out, 1, high from the cycle after an accepted start until return to IDLE
- err, out, 1, sticky PE timeout flag; cleared by the next accepted start or by rst
- tile_addr, out, clog2(NTILES), tile index for the activation/weight memories
- pe_clr, out, 1, one-cycle PE clear pulse at the start of each tile
- pe_en, out, 1, PE enable; held high throughout RUN
- pe_finish, in, 1, PE tile done; sampled only in RUN
- pe_psum, in, OUT_LEN*DW, PE partial sums; element j is bits [j*DW +: DW]; valid while pe_finish=1
- result, out, OUT_LEN*DW, saturated layer output, same packing as pe_psum
- result_valid, out, 1, result available
- result_ready, in, 1, consumer accepts result

Behaviour:
- Reset (asynchronous, active-high, may occur at any time including mid-layer):
  - state=IDLE; all outputs 0 (busy, err, tile_addr, pe_clr, pe_en, result, result_valid); accumulators 0; counters 0.
- States: IDLE, LOAD, RUN, ACC, OUT, ERR.
- IDLE:
  - start=1 -> LOAD; clears accumulators, err and tile_addr.
  - start in any other state is ignored.
- LOAD:
  - pe_clr=1 on the first cycle only; tile_addr stable.
  - Stays MEM_LAT cycles, then -> RUN.
- RUN:
  - pe_en=1; the watchdog counts RUN cycles.
  - pe_finish=1 -> ACC; each acc[j] += sign-extended pe_psum[j], captured on that edge.
  - Otherwise, on the TIMEOUT-th RUN cycle with no finish -> ERR.
  - pe_finish arriving on the timeout cycle counts as finish.
- ACC (1 cycle):
  - If tile_addr == NTILES-1 -> OUT; result[j] = sat(acc[j]) registered; result_valid=1.
  - Else tile_addr+1 -> LOAD.
- OUT:
  - result and result_valid hold stable while result_ready=0.
  - result_valid & result_ready -> IDLE; result_valid drops next cycle.
  - result keeps its value until the next OUT.
- ERR:
  - err=1, pe_en=0, busy=0; -> IDLE next cycle.
  - err stays set until the next accepted start.
- Saturation: values above 2^(DW-1)-1 map to 0x7FFF; values below -2^(DW-1) map to 0x8000 (DW=16). No rounding or shift.
- Timing:
  - Per-tile latency = MEM_LAT + F + 1 cycles, where F is the number of RUN cycles including the finish cycle.
  - Layer latency from start to result_valid = 1 + NTILES*(MEM_LAT+F+1).
- busy: 1 in LOAD/RUN/ACC/OUT, 0 in IDLE/ERR.
- pe_finish outside RUN: ignored, no accumulation.

Decomposition:
- Shared package fc_pkg:
  - State enum.
  - DW, OUT_LEN, IN_LEN defaults.
  - Saturation function sat_dw(acc).
  - clog2-based width constants.
- One sub-module fc_acc_bank: OUT_LEN x ACC_W accumulator registers with clear, add-enable and saturated output.
- The FSM, watchdog and tile counter stay in fc_tile_sequencer.

Test Plan:
- Nominal: PE model returns pe_psum elements = 0x0040 with finish 3 cycles after pe_en -> after 49 tiles every result element = 0x0C40; result_valid at cycle 1+49*(2+3+1)=295 after start.
- Positive saturation: every psum element = 0x7000 each tile -> all results 0x7FFF; negative 0x9000 -> all 0x8000.
- Mixed sign: even tiles +0x0100, odd tiles -0x0100 (25 even, 24 odd) -> results 0x0100.
- Timeout: PE never asserts finish -> ERR after 256 RUN cycles, err=1, busy=0; next start clears err and completes normally.
- Backpressure: result_ready held 0 for 10 cycles after result_valid -> result and result_valid stable; one handshake cycle -> IDLE.
- Reset mid-layer at tile 20 -> all outputs 0 immediately; a new start gives a clean 0x0C40 result; a start pulse during RUN is ignored.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared state encoding, default layer geometry and saturation helper for the
// fully-connected tile sequencer.
package fc_pkg;
  localparam int FC_DW      = 16;
  localparam int FC_IN_LEN  = 784;
  localparam int FC_OUT_LEN = 64;
  localparam int FC_TILE_K  = 16;
  localparam int FC_NTILES  = FC_IN_LEN / FC_TILE_K;
  localparam int FC_AW      = (FC_NTILES > 1) ? $clog2(FC_NTILES) : 1;
  localparam int FC_ACC_W   = FC_DW + 6;
  localparam int SAT_W      = 64;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ACC, S_OUT, S_ERR} fc_state_e;

  // Clamp a sign-extended accumulator into the dw-bit signed range.
  function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] v,
                                                     input int dw);
    logic signed [SAT_W-1:0] hi, lo;
    hi = $signed((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction
endpackage

// File: rtl/fc_tile_sequencer_if.sv
// Controller / PE / result-consumer signals of the FC tile sequencer.
interface fc_tile_sequencer_if import fc_pkg::*; #(
  parameter int DW      = FC_DW,
  parameter int OUT_LEN = FC_OUT_LEN,
  parameter int AW      = FC_AW
);
  logic                         start;
  logic                         busy;
  logic                         err;
  logic [AW-1:0]                tile_addr;
  logic                         pe_clr;
  logic                         pe_en;
  logic                         pe_finish;
  logic [OUT_LEN-1:0][DW-1:0]   pe_psum;
  logic [OUT_LEN-1:0][DW-1:0]   result;
  logic                         result_valid;
  logic                         result_ready;

  modport master (
    input  start, pe_finish, pe_psum, result_ready,
    output busy, err, tile_addr, pe_clr, pe_en, result, result_valid
  );
  modport slave (
    output start, pe_finish, pe_psum, result_ready,
    input  busy, err, tile_addr, pe_clr, pe_en, result, result_valid
  );
endinterface

// File: rtl/fc_acc_bank.sv
// OUT_LEN widened accumulators for PE partial sums, with saturated DW-bit view.
module fc_acc_bank import fc_pkg::*; #(
  parameter int DW      = FC_DW,
  parameter int OUT_LEN = FC_OUT_LEN,
  parameter int ACC_W   = FC_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       add,
  input  logic [OUT_LEN-1:0][DW-1:0] psum,
  output logic [OUT_LEN-1:0][DW-1:0] acc_sat
);
  for (genvar j = 0; j < OUT_LEN; j++) begin : g_lane
    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      acc <= '0;
      else if (clr) acc <= '0;
      else if (add) acc <= acc + ACC_W'($signed(psum[j]));
    end

    assign acc_sat[j] = DW'(sat_dw(SAT_W'($signed(acc)), DW));
  end
endmodule

// File: rtl/fc_tile_sequencer.sv
// Walks one FC layer through a 1xTILE_K x TILE_KxOUT_LEN PE tile, accumulates
// the per-tile partial sums and hands out the saturated layer result.
module fc_tile_sequencer import fc_pkg::*; #(
  parameter int DW      = FC_DW,
  parameter int IN_LEN  = FC_IN_LEN,
  parameter int OUT_LEN = FC_OUT_LEN,
  parameter int TILE_K  = FC_TILE_K,
  parameter int MEM_LAT = 2,
  parameter int TIMEOUT = 256,
  parameter int ACC_W   = DW + 6
) (
  input logic                 clk,
  input logic                 rst,
  fc_tile_sequencer_if.master bus
);
  localparam int NTILES = IN_LEN / TILE_K;
  localparam int AW     = (NTILES > 1) ? $clog2(NTILES) : 1;
  localparam int LW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int WW     = $clog2(TIMEOUT + 1);

  fc_state_e                  state, state_n;
  logic [LW-1:0]              lcnt;
  logic [WW-1:0]              wd;
  logic [AW-1:0]              tile_addr;
  logic                       err;
  logic [OUT_LEN-1:0][DW-1:0] result, acc_sat;
  logic                       acc_clr, acc_add;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // A finish on the last watchdog cycle still wins over the timeout.
  always_comb begin
    state_n = state;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        state_n = S_LOAD;
        acc_clr = 1'b1;
      end
      S_LOAD: if (lcnt == LW'(MEM_LAT - 1)) state_n = S_RUN;
      S_RUN: begin
        if (bus.pe_finish) begin
          state_n = S_ACC;
          acc_add = 1'b1;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          state_n = S_ERR;
        end
      end
      S_ACC:  state_n = (tile_addr == AW'(NTILES - 1)) ? S_OUT : S_LOAD;
      S_OUT:  if (bus.result_ready) state_n = S_IDLE;
      S_ERR:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt      <= '0;
      wd        <= '0;
      tile_addr <= '0;
      err       <= 1'b0;
      result    <= '0;
    end else begin
      lcnt <= (state == S_LOAD && state_n == S_LOAD) ? lcnt + 1'b1 : '0;
      wd   <= (state == S_RUN && state_n == S_RUN) ? wd + 1'b1 : '0;
      if (state == S_IDLE && bus.start) begin
        tile_addr <= '0;
        err       <= 1'b0;
      end else if (state == S_ACC && state_n == S_LOAD) begin
        tile_addr <= tile_addr + 1'b1;
      end
      if (state_n == S_ERR) err <= 1'b1;
      if (state == S_ACC && state_n == S_OUT) result <= acc_sat;
    end
  end

  fc_acc_bank #(.DW(DW), .OUT_LEN(OUT_LEN), .ACC_W(ACC_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .add     (acc_add),
    .psum    (bus.pe_psum),
    .acc_sat (acc_sat)
  );

  assign bus.busy         = (state == S_LOAD) || (state == S_RUN) ||
                            (state == S_ACC)  || (state == S_OUT);
  assign bus.pe_en        = (state == S_RUN);
  assign bus.pe_clr       = (state == S_LOAD) && (lcnt == '0);
  assign bus.result_valid = (state == S_OUT);
  assign bus.err          = err;
  assign bus.tile_addr    = tile_addr;
  assign bus.result       = result;
endmodule

// File: tb/tb_fc_tile_sequencer.sv
// Randomized scoreboard bench for fc_tile_sequencer with a behavioural PE model.
module tb_fc_tile_sequencer;
  localparam int DW = 16, OUT_LEN = 64, NT = 49, AW = 6, MEM_LAT = 2, TIMEOUT = 256;
  typedef logic [OUT_LEN-1:0][DW-1:0] vec_t;
  typedef struct { vec_t data; int lat; int t0; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fc_tile_sequencer_if #(.DW(DW), .OUT_LEN(OUT_LEN), .AW(AW)) bus();
  fc_tile_sequencer #(.MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   tbl [NT][OUT_LEN];
  int   ftbl[NT];
  bit   glitch = 0;
  int   rdy_mode = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkv(string name, vec_t act, vec_t exp);
    bit found;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      found = 0;
      for (int j = 0; j < OUT_LEN; j++)
        if (!found && act[j] !== exp[j]) begin
          found = 1;
          $display("FAIL %s: element %0d got 0x%0h expected 0x%0h", name, j, act[j], exp[j]);
        end
    end
  endtask

  task automatic fill_const(int ve, int vo, int fmin, int fmax);
    for (int t = 0; t < NT; t++) begin
      ftbl[t] = int'($urandom_range(fmax, fmin));
      for (int j = 0; j < OUT_LEN; j++) tbl[t][j] = (t % 2 == 0) ? ve : vo;
    end
  endtask

  task automatic fill_rand(int lo, int hi, int fmin, int fmax);
    for (int t = 0; t < NT; t++) begin
      ftbl[t] = int'($urandom_range(fmax, fmin));
      for (int j = 0; j < OUT_LEN; j++) tbl[t][j] = int'($urandom_range(hi - lo)) + lo;
    end
  endtask

  // Reference: sum every tile's psum per column, clamp to DW bits; latency from tile timing.
  task automatic issue(bit push);
    exp_t e;
    vec_t d;
    int   lat;
    lat = 1;
    for (int t = 0; t < NT; t++) lat += MEM_LAT + ftbl[t] + 1;
    for (int j = 0; j < OUT_LEN; j++) begin
      longint s;
      s = 0;
      for (int t = 0; t < NT; t++) s += tbl[t][j];
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      d[j] = DW'(s);
    end
    @(negedge clk);
    bus.start = 1'b1;
    e.data = d; e.lat = lat; e.t0 = cyc;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("layer_done_in_budget", n < budget, 1);
  endtask

  // PE model: finish on the ftbl[tile]-th enabled cycle (0 = never), spurious finishes when idle.
  initial begin
    int rc, t;
    rc = 0;
    bus.pe_finish = 1'b0;
    bus.pe_psum   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rc = 0;
        bus.pe_finish = 1'b0;
      end else if (bus.pe_en) begin
        t = int'(bus.tile_addr);
        rc++;
        if (t < NT && ftbl[t] != 0 && rc == ftbl[t]) begin
          bus.pe_finish = 1'b1;
          for (int j = 0; j < OUT_LEN; j++) bus.pe_psum[j] = DW'(tbl[t][j]);
        end else begin
          bus.pe_finish = 1'b0;
        end
      end else begin
        rc = 0;
        bus.pe_finish = glitch && ($urandom_range(2) == 0);
        for (int j = 0; j < OUT_LEN; j++) bus.pe_psum[j] = DW'($urandom);
      end
    end
  end

  // Consumer: always ready, random ready, or 10 cycles of backpressure per result.
  initial begin
    int hold;
    hold = 0;
    bus.result_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.result_ready = 1'b1;
        1: bus.result_ready = ($urandom_range(1) == 1);
        default: begin
          if (bus.result_valid) begin
            bus.result_ready = (hold >= 10);
            hold++;
          end else begin
            bus.result_ready = 1'b0;
            hold = 0;
          end
        end
      endcase
    end
  end

  // Monitor: pops on each new result, checks stability under backpressure and drop after handshake.
  initial begin
    bit   in_out, drop;
    vec_t cur;
    exp_t e;
    in_out = 0; drop = 0; cur = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        in_out = 0;
        drop   = 0;
      end else if (drop) begin
        chk("valid_drop_after_handshake", bus.result_valid, 0);
        chkv("result_held_after_out", bus.result, cur);
        drop = 0;
      end else if (bus.result_valid) begin
        if (!in_out) begin
          chk("result_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chkv("result", bus.result, e.data);
            chk("latency", cyc - e.t0, e.lat);
          end
          cur    = bus.result;
          in_out = 1;
        end else begin
          chkv("result_stable", bus.result, cur);
        end
        if (bus.result_ready) begin
          in_out = 0;
          drop   = 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation reached time %0t without finishing", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int n, runc;
    bus.start = 1'b0;
    fill_const(0, 0, 3, 3);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_tile_addr", bus.tile_addr, 0);
    chk("reset_pe_clr", bus.pe_clr, 0);
    chk("reset_pe_en", bus.pe_en, 0);
    chk("reset_result_valid", bus.result_valid, 0);
    chkv("reset_result", bus.result, '0);
    rst = 1'b0;

    // nominal: 49 x 0x40 -> 0x0C40 at cycle 295
    fill_const(64, 64, 3, 3);
    issue(1);
    wait_idle(2000);

    // saturation both ways and mixed sign, random PE latency and random ready
    rdy_mode = 1;
    fill_const(28672, 28672, 1, 5);  issue(1); wait_idle(3000);
    fill_const(-28672, -28672, 1, 5); issue(1); wait_idle(3000);
    fill_const(256, -256, 1, 4);     issue(1); wait_idle(3000);

    // random data with spurious finishes outside RUN
    glitch = 1;
    repeat (2) begin fill_rand(-1024, 1023, 1, 6);    issue(1); wait_idle(3000); end
    repeat (2) begin fill_rand(-32768, 32767, 1, 6);  issue(1); wait_idle(3000); end
    glitch = 0;

    // backpressure
    rdy_mode = 2;
    fill_const(64, 64, 3, 3);
    issue(1);
    wait_idle(2000);
    rdy_mode = 0;

    // timeout: PE never finishes
    fill_const(64, 64, 0, 0);
    issue(0);
    runc = 0; n = 0;
    while (!bus.err && n < 1000) begin
      @(negedge clk);
      #1;
      if (bus.pe_en) runc++;
      n++;
    end
    chk("timeout_reached", n < 1000, 1);
    chk("timeout_run_cycles", runc, TIMEOUT);
    chk("err_state_busy", bus.busy, 0);
    chk("err_state_pe_en", bus.pe_en, 0);
    @(negedge clk);
    #1;
    chk("err_sticky_in_idle", bus.err, 1);
    chk("idle_after_err_busy", bus.busy, 0);
    fill_const(64, 64, 3, 3);
    issue(1);
    #1;
    chk("err_cleared_by_start", bus.err, 0);
    wait_idle(2000);

    // reset mid-layer at tile 20
    fill_const(64, 64, 3, 3);
    issue(0);
    n = 0;
    while (!(bus.tile_addr == AW'(20) && bus.pe_en) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_tile_20", n < 500, 1);
    #3 rst = 1'b1;
    #1;
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_err", bus.err, 0);
    chk("midreset_tile_addr", bus.tile_addr, 0);
    chk("midreset_pe_clr", bus.pe_clr, 0);
    chk("midreset_pe_en", bus.pe_en, 0);
    chk("midreset_result_valid", bus.result_valid, 0);
    chkv("midreset_result", bus.result, '0);
    @(negedge clk);
    rst = 1'b0;

    // clean layer after reset, with an ignored start pulse during RUN
    fill_const(64, 64, 3, 3);
    issue(1);
    n = 0;
    while (!bus.pe_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("run_reached_after_reset", n < 50, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(2000);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
